// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and fills the IF/ID register, with stall, redirect and halt handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] PC_STEP      = 32'd1,
  parameter int          MEM_DEPTH    = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] DEPTH     = 32'(MEM_DEPTH);
  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_HALT   = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        halt_cond;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Halt on a PC past the end of memory, or on an all-zero word when enabled.
  assign halt_cond = (pc_q >= DEPTH) || (HALT_ON_ZERO && (imem_data == 32'd0));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (state_q == ST_RUN) begin
      if (redirect_valid) begin
        pc_d    = redirect_target;
        instr_d = NOP;
        ifpc_d  = 32'd0;
        valid_d = 1'b0;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (halt_cond) begin
        state_d = ST_HALT;
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_data;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + PC_STEP;
        count_d = sat_inc(count_q);
      end
    end else begin
      // IF/ID already flushed on entry to HALT; only a redirect restarts fetch.
      if (redirect_valid) begin
        state_d = ST_RUN;
        pc_d    = redirect_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ifpc_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected post-edge
// state, a monitor pops and compares it just after each rising edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        halt;
    logic [31:0] count;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] mem [0:31];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range addresses return a non-zero word so only the PC bound halts.
  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'd32) imem_data = mem[imem_addr[4:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".imem_addr"},   imem_addr,          e.pc);
    chk({tag, ".if_id_valid"}, 32'(if_id_valid),   32'(e.valid));
    chk({tag, ".if_id_instr"}, if_id_instr,        e.instr);
    chk({tag, ".if_id_pc"},    if_id_pc,           e.ifpc);
    chk({tag, ".halted"},      32'(halted),        32'(e.halt));
    chk({tag, ".fetch_count"}, fetch_count,        e.count);
  endtask

  // Drive one cycle of inputs at a negedge, queue the state expected after
  // the following rising edge, then wait for the next negedge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rt,
                      input logic [31:0] epc, input logic ev, input logic [31:0] ei,
                      input logic [31:0] eifpc, input logic eh, input logic [31:0] ec);
    exp_t e;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    e.pc = epc; e.valid = ev; e.instr = ei; e.ifpc = eifpc; e.halt = eh; e.count = ec;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_all("edge", e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t rst_e;
    int   drain;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0] = 32'h0050_0093; mem[1] = 32'h0030_0113; mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4020_8233; mem[4] = 32'h0041_F2B3; mem[5] = 32'h0041_E333;
    mem[6] = 32'h0041_9393; mem[7] = 32'h0011_D413; mem[8] = 32'h0080_2023;
    mem[9] = 32'h0000_2483;
    rst_e.pc = 32'd0; rst_e.valid = 1'b0; rst_e.instr = NOP;
    rst_e.ifpc = 32'd0; rst_e.halt = 1'b0; rst_e.count = 32'd0;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    #1;
    chk_all("reset", rst_e);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Free run from RESET_PC: three fetches
    for (int n = 1; n <= 3; n++)
      step(0, 0, 0, 32'(n), 1, mem[n-1], 32'(n-1), 0, 32'(n));
    // Stall two cycles at pc=3
    repeat (2) step(1, 0, 0, 32'd3, 1, mem[2], 32'd2, 0, 32'd3);
    for (int n = 4; n <= 9; n++)
      step(0, 0, 0, 32'(n), 1, mem[n-1], 32'(n-1), 0, 32'(n));
    // Redirect wins over stall at pc=9
    step(1, 1, 32'd0, 32'd0, 0, NOP, 32'd0, 0, 32'd9);
    for (int n = 1; n <= 10; n++)
      step(0, 0, 0, 32'(n), 1, mem[n-1], 32'(n-1), 0, 32'(9 + n));
    // Zero word at pc=10 halts; then frozen regardless of stall
    step(0, 0, 0, 32'd10, 0, NOP, 32'd9, 1, 32'd19);
    for (int k = 0; k < 5; k++)
      step(k[0], 0, 0, 32'd10, 0, NOP, 32'd9, 1, 32'd19);
    // Redirect out of HALT, then resume from 0
    step(0, 1, 32'd0, 32'd0, 0, NOP, 32'd9, 0, 32'd19);
    for (int n = 1; n <= 5; n++)
      step(0, 0, 0, 32'(n), 1, mem[n-1], 32'(n-1), 0, 32'(19 + n));

    // Asynchronous reset between edges with pc=5
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", rst_e);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 2; n++)
      step(0, 0, 0, 32'(n), 1, mem[n-1], 32'(n-1), 0, 32'(n));
    // Redirect beyond MEM_DEPTH is accepted, next edge halts
    step(0, 1, 32'd40, 32'd40, 0, NOP, 32'd0, 0, 32'd2);
    step(0, 0, 0, 32'd40, 0, NOP, 32'd0, 1, 32'd2);

    drain = 0;
    while (sb_q.size() > 0 && drain < 5) begin
      @(negedge clk);
      drain++;
    end
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
